// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DAT_HI = 3'd2,
        DAT_LO = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Shifts accepted bytes into an instruction word (high byte first); with
// IMEM_LOADER_CSUM_EN it also keeps a running XOR of every shifted byte.
module byte_pair_assembler
    import imem_loader_pkg::*;
#(
    parameter int unsigned WORD_W = BYTE_W * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic [BYTE_W-1:0] in_data,
`ifdef IMEM_LOADER_CSUM_EN
    input  logic              clear,
    output logic [BYTE_W-1:0] csum,
`endif
    output logic [WORD_W-1:0] word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (shift) begin
            word <= {word[WORD_W-BYTE_W-1:0], in_data};
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    // Cleared while waiting for a new image so each image starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (shift) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: rtl/imem_loader.sv
// Loads a big-endian word-count-prefixed byte stream into instruction memory
// and holds the CPU in reset until done. Optional macro: IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = BYTE_W * BYTES_PER_WORD,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned CAPACITY = (32'd1 << ADDR_W) - BASE_ADDR;
    localparam int unsigned CNT_W    = ADDR_W + 1;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   count_hi_q;
    logic [CNT_W-1:0]    remaining_q;
    logic [2*BYTE_W-1:0] count_w;
    logic                accept;
    logic                shift;
    logic                csum_ok;

    function automatic logic accepts_bytes(input state_t s);
`ifdef IMEM_LOADER_CSUM_EN
        return s inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO, CSUM};
`else
        return s inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO};
`endif
    endfunction

    assign accept  = in_valid && in_ready;
    assign count_w = {count_hi_q, in_data};
    assign shift   = accept && (state_q == DAT_HI || state_q == DAT_LO);

    byte_pair_assembler #(.WORD_W(DATA_W)) u_asm (
        .clk     (CLK),
        .rst_n   (RST),
        .shift   (shift),
        .in_data (in_data),
`ifdef IMEM_LOADER_CSUM_EN
        .clear   (state_q == CNT_HI),
        .csum    (),
`endif
        .word    (write_data)
    );

`ifdef IMEM_LOADER_CSUM_EN
    assign csum_ok = (in_data == u_asm.csum);
`else
    assign csum_ok = 1'b1;
`endif

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            CNT_HI: if (accept) state_d = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (count_w == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else if (32'(count_w) > CAPACITY) begin
                        state_d = ERR;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: if (accept) state_d = DAT_LO;
            DAT_LO: if (accept) state_d = WRITE;
            WRITE: begin
                if (remaining_q == CNT_W'(1)) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DAT_HI;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: if (accept) state_d = csum_ok ? DONE : ERR;
`endif
            DONE:    if (start) state_d = CNT_HI;
            ERR:     if (start) state_d = CNT_HI;
            default: state_d = CNT_HI;
        endcase
    end

    // State and status outputs are registered from the next state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= CNT_HI;
            in_ready <= 1'b1;
            we       <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= accepts_bytes(state_d);
            we       <= (state_d == WRITE);
            done     <= (state_d == DONE);
            error    <= (state_d == ERR);
            cpu_hold <= (state_d != DONE);
        end
    end

    // Word count, remaining words and write address
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_hi_q  <= '0;
            remaining_q <= '0;
            write_addr  <= ADDR_W'(BASE_ADDR);
        end else begin
            if (state_q == CNT_HI && accept) begin
                count_hi_q <= in_data;
            end
            if (state_q == CNT_LO && accept) begin
                remaining_q <= CNT_W'(count_w);
            end
            if (state_q == WRITE) begin
                remaining_q <= remaining_q - CNT_W'(1);
                write_addr  <= write_addr + ADDR_W'(1);
            end
            if ((state_q == DONE || state_q == ERR) && start) begin
                write_addr <= ADDR_W'(BASE_ADDR);
            end
        end
    end

    logic unused_ok;
    assign unused_ok = csum_ok;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default build, checksum off).
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, we, cpu_hold, done, error;
    logic [7:0]  write_addr;
    logic [15:0] write_data;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int c0;
    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    imem_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Write-port monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (we === 1'b1) begin
            wa.push_back(write_addr);
            wd.push_back(write_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge CLK);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic check_basic_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            chk({tag, "_a0"}, 32'(wa[0]), 32'd0);
            chk({tag, "_d0"}, 32'(wd[0]), 32'h1234);
            chk({tag, "_a1"}, 32'(wa[1]), 32'd1);
            chk({tag, "_d1"}, 32'(wd[1]), 32'hABCD);
            chk({tag, "_a2"}, 32'(wa[2]), 32'd2);
            chk({tag, "_d2"}, 32'(wd[2]), 32'h0001);
        end
    endtask

    logic [7:0] basic [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    int         gaps  [8] = '{3, 0, 5, 1, 2, 4, 0, 3};

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(write_addr), 32'd0);
        chk("rst_data", 32'(write_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        @(negedge CLK);
        RST = 1'b1;

        // Basic load, back-to-back bytes
        @(negedge CLK);
        send_byte(basic[0], 0);
        c0 = cyc;
        for (int i = 1; i < 8; i++) send_byte(basic[i], 0);
        chk("basic_last_we", 32'(we), 32'd1);
        chk("basic_last_done", 32'(done), 32'd0);
        @(posedge CLK);
        #1;
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_hold", 32'(cpu_hold), 32'd0);
        chk("basic_ready", 32'(in_ready), 32'd0);
        chk("basic_cycles", 32'(cyc - c0), 32'd10);
        chk("basic_end_addr", 32'(write_addr), 32'd3);
        check_basic_writes("basic");

        // Restart, then empty image
        pulse_start();
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_addr", 32'(write_addr), 32'd0);
        chk("restart_ready", 32'(in_ready), 32'd1);
        wa.delete();
        wd.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_hold", 32'(cpu_hold), 32'd0);
        chk("empty_addr", 32'(write_addr), 32'd0);
        repeat (2) @(negedge CLK);
        chk("empty_nwrites", 32'(wa.size()), 32'd0);

        // Oversize image: 257 words > 256 capacity
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("over_error", 32'(error), 32'd1);
        chk("over_ready", 32'(in_ready), 32'd0);
        chk("over_hold", 32'(cpu_hold), 32'd1);
        chk("over_done", 32'(done), 32'd0);
        repeat (3) @(negedge CLK);
        chk("over_nwrites", 32'(wa.size()), 32'd0);
        chk("over_stuck", 32'(error), 32'd1);
        pulse_start();
        chk("over_clear_error", 32'(error), 32'd0);
        chk("over_clear_ready", 32'(in_ready), 32'd1);

        // Backpressure: same image with idle gaps
        for (int i = 0; i < 8; i++) send_byte(basic[i], gaps[i]);
        @(posedge CLK);
        #1;
        chk("bp_done", 32'(done), 32'd1);
        check_basic_writes("bp");

        // Start ignored mid-load, then reset after the first word
        pulse_start();
        wa.delete();
        wd.delete();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        pulse_start();
        chk("ign_start_ready", 32'(in_ready), 32'd1);
        chk("ign_start_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(posedge CLK);
        #1;
        chk("mid_addr", 32'(write_addr), 32'd1);
        chk("mid_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) chk("mid_d0", 32'(wd[0]), 32'h1122);
        #2;
        RST = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(write_addr), 32'd0);
        chk("mid_rst_data", 32'(write_data), 32'd0);
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        wa.delete();
        wd.delete();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 1);
        @(posedge CLK);
        #1;
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("reload_a0", 32'(wa[0]), 32'd0);
            chk("reload_d0", 32'(wd[0]), 32'hBEEF);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
